sram_bus_bridge: RTL and testbench
==================================

// Module: sram_bus_bridge
// PURPOSE
//  Sits directly downstream of the mips core's inst_sram_* / data_sram_* ports.
//  Converts them to one shared handshake bus (req/addr_ok/data_ok) with variable latency.
//  Arbitrates fetch vs load/store: data has priority, one outstanding transaction.
//  Returns read data with a valid pulse; stall_o freezes the core while the bus is busy.
// PARAMETERS
//  ADDR_W  32  address width, core side and bus side
//  DATA_W  32  data width; byte strobe width is DATA_W/8 (4)
// PORTS
//  clk          in   1       single clock, all logic rising-edge
//  rst          in   1       asynchronous, active-high reset
//  inst_req     in   1       fetch request (core inst_sram_en)
//  inst_addr    in   ADDR_W  fetch address
//  inst_rdata   out  DATA_W  fetched word, held until next fetch completes
//  inst_valid   out  1       1-cycle pulse: inst_rdata updated
//  data_req     in   1       load/store request (core data_sram_en)
//  data_we      in   1       1 = store, 0 = load
//  data_wen     in   4       store byte strobes
//  data_addr    in   ADDR_W  load/store address
//  data_wdata   in   DATA_W  store data
//  data_rdata   out  DATA_W  load data, held until next load completes
//  data_valid   out  1       1-cycle pulse: load or store completed
//  stall_o      out  1       1 while bridge busy; core holds its request inputs stable
//  bus_req      out  1       bus address-phase request
//  bus_wr       out  1       1 = write transaction
//  bus_wstrb    out  4       write strobes (0 for reads)
//  bus_addr     out  ADDR_W  transaction address
//  bus_wdata    out  DATA_W  write data
//  bus_addr_ok  in   1       address accepted this cycle (while bus_req=1)
//  bus_data_ok  in   1       read data valid / write done this cycle
//  bus_rdata    in   DATA_W  read data, valid with bus_data_ok
// BEHAVIOUR
//  Reset: state IDLE, pending flags 0, capture regs 0; all outputs 0.
//  States: IDLE, D_ADDR, D_WAIT, I_ADDR, I_WAIT. stall_o = (state != IDLE), registered-state based.
//  IDLE: sample data_req/inst_req. Capture both requests' fields into regs, set pend_i if inst_req.
//   data_req=1 -> D_ADDR; else inst_req=1 -> I_ADDR; else stay IDLE.
//  Request inputs ignored in all non-IDLE states (only captured copies drive the bus).
//  D_ADDR: bus_req=1, bus_addr/wdata from capture, bus_wr=we, bus_wstrb=we?wen:0.
//   bus_addr_ok=1 -> D_WAIT; bus_req low from next cycle.
//  I_ADDR: bus_req=1, bus_wr=0, bus_wstrb=0, bus_addr=captured inst addr; addr_ok -> I_WAIT.
//  Bus outputs when bus_req=0: bus_wr=0, bus_wstrb=0; addr/wdata hold last value.
//  D_WAIT on bus_data_ok: data_valid pulses next cycle; load -> data_rdata<=bus_rdata;
//   store -> data_rdata unchanged. Next state I_ADDR if pend_i else IDLE.
//  I_WAIT on bus_data_ok: inst_rdata<=bus_rdata, inst_valid pulses next cycle, pend_i<=0, -> IDLE.
//  Store with data_wen=0000: still issued as write with bus_wstrb=0000.
//  bus_data_ok in IDLE, D_ADDR, I_ADDR: ignored (no valid, no state change).
//  Bus contract: data_ok never in the same cycle as its own addr_ok.
//  Latency (req seen in IDLE at cycle 0, addr_ok c1, data_ok c2): valid high c3, stall_o high c1-c2.
//  Both requests at cycle 0: data serviced first; fetch issued the cycle after data_ok, no IDLE gap.
//  addr_ok stalls indefinitely: stay in x_ADDR, bus_req and fields held stable.
//  Reset mid-transaction: abort immediately to IDLE; late data_ok after reset ignored.
// TESTING
//  Fetch only: inst_req=1 addr=0x00000040, addr_ok c1, data_ok c2 rdata=0x24010005 -> inst_valid c3, inst_rdata=0x24010005.
//  Simultaneous: data load addr 0x100, fetch addr 0x44 -> bus addr order 0x100 then 0x44; data_valid before inst_valid.
//  Store: we=1 wen=0011 wdata=0xDEADBEEF addr 0x200 -> bus_wr=1 wstrb=0011; data_valid pulse, data_rdata unchanged.
//  Backpressure: addr_ok held 0 for 5 cycles -> bus_req/addr stable all 5, stall_o=1, inputs changing ignored.
//  Spurious: data_ok pulsed in IDLE and in D_ADDR -> no valid pulse, no state change.
//  Reset in D_WAIT, then data_ok -> all outputs 0, state IDLE, no data_valid.

Source files
------------

// File: rtl/sram_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_bridge
// Purpose  : Merges the core's fetch and load/store SRAM ports onto a single
//            req/addr_ok/data_ok bus. Data has priority, one transaction
//            outstanding at a time.
// Revision : 1.0  initial release
// ============================================================================
module sram_bus_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic [DATA_W-1:0]   inst_rdata,
   output logic                inst_valid,
   input  logic                data_req,
   input  logic                data_we,
   input  logic [DATA_W/8-1:0] data_wen,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic [DATA_W-1:0]   data_rdata,
   output logic                data_valid,
   output logic                stall_o,
   output logic                bus_req,
   output logic                bus_wr,
   output logic [DATA_W/8-1:0] bus_wstrb,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic                bus_addr_ok,
   input  logic                bus_data_ok,
   input  logic [DATA_W-1:0]   bus_rdata
);

   localparam int c_STRB_W = DATA_W / 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_D_ADDR = 3'd1,
      S_D_WAIT = 3'd2,
      S_I_ADDR = 3'd3,
      S_I_WAIT = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_d_we;
   logic [c_STRB_W-1:0] r_d_wen;
   logic [ADDR_W-1:0]   r_i_addr;
   logic                r_pend_i;
   logic [ADDR_W-1:0]   r_bus_addr;
   logic [DATA_W-1:0]   r_bus_wdata;
   logic [DATA_W-1:0]   r_inst_rdata;
   logic [DATA_W-1:0]   r_data_rdata;
   logic                r_inst_valid;
   logic                r_data_valid;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (data_req)      w_next = S_D_ADDR;
            else if (inst_req) w_next = S_I_ADDR;
         end
         S_D_ADDR: if (bus_addr_ok) w_next = S_D_WAIT;
         // A pending fetch goes straight out after the data beat, no idle gap
         S_D_WAIT: if (bus_data_ok) w_next = r_pend_i ? S_I_ADDR : S_IDLE;
         S_I_ADDR: if (bus_addr_ok) w_next = S_I_WAIT;
         S_I_WAIT: if (bus_data_ok) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_d_we       <= 1'b0;
         r_d_wen      <= '0;
         r_i_addr     <= '0;
         r_pend_i     <= 1'b0;
         r_bus_addr   <= '0;
         r_bus_wdata  <= '0;
         r_inst_rdata <= '0;
         r_data_rdata <= '0;
         r_inst_valid <= 1'b0;
         r_data_valid <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_inst_valid <= 1'b0;
         r_data_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_d_we   <= data_we;
               r_d_wen  <= data_wen;
               r_i_addr <= inst_addr;
               r_pend_i <= inst_req;
               // Bus address/wdata only move when a transaction is launched
               if (data_req) begin
                  r_bus_addr  <= data_addr;
                  r_bus_wdata <= data_wdata;
               end else if (inst_req) begin
                  r_bus_addr  <= inst_addr;
               end
            end
            S_D_WAIT: begin
               if (bus_data_ok) begin
                  r_data_valid <= 1'b1;
                  if (!r_d_we) r_data_rdata <= bus_rdata;
                  if (r_pend_i) r_bus_addr  <= r_i_addr;
               end
            end
            S_I_WAIT: begin
               if (bus_data_ok) begin
                  r_inst_rdata <= bus_rdata;
                  r_inst_valid <= 1'b1;
                  r_pend_i     <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus_req    = (r_state == S_D_ADDR) || (r_state == S_I_ADDR);
   assign bus_wr     = (r_state == S_D_ADDR) && r_d_we;
   assign bus_wstrb  = ((r_state == S_D_ADDR) && r_d_we) ? r_d_wen : '0;
   assign bus_addr   = r_bus_addr;
   assign bus_wdata  = r_bus_wdata;
   assign stall_o    = (r_state != S_IDLE);
   assign inst_rdata = r_inst_rdata;
   assign inst_valid = r_inst_valid;
   assign data_rdata = r_data_rdata;
   assign data_valid = r_data_valid;

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bus_bridge
// Purpose  : Directed self-checking bench for sram_bus_bridge.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_bus_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_valid;
   logic        data_req;
   logic        data_we;
   logic [3:0]  data_wen;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_valid;
   logic        stall_o;
   logic        bus_req;
   logic        bus_wr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sram_bus_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_rdata(inst_rdata), .inst_valid(inst_valid),
      .data_req(data_req), .data_we(data_we), .data_wen(data_wen),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_rdata(data_rdata), .data_valid(data_valid),
      .stall_o(stall_o),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
      .bus_rdata(bus_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      inst_req = 1'b0; inst_addr = '0;
      data_req = 1'b0; data_we = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
      tick(); tick();
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_valids", 32'({inst_valid, data_valid}), 32'd0);
      chk("rst_rdata", inst_rdata | data_rdata, 32'd0);
      rst = 1'b0;

      // Fetch only
      inst_req = 1'b1; inst_addr = 32'h0000_0040;
      tick();
      chk("f_bus_req", 32'(bus_req), 32'd1);
      chk("f_bus_addr", bus_addr, 32'h40);
      chk("f_bus_wr", 32'(bus_wr), 32'd0);
      chk("f_stall_c1", 32'(stall_o), 32'd1);
      inst_req = 1'b0; bus_addr_ok = 1'b1;
      tick();
      chk("f_req_drop", 32'(bus_req), 32'd0);
      chk("f_stall_c2", 32'(stall_o), 32'd1);
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2401_0005;
      tick();
      bus_data_ok = 1'b0;
      chk("f_inst_valid", 32'(inst_valid), 32'd1);
      chk("f_inst_rdata", inst_rdata, 32'h2401_0005);
      chk("f_stall_c3", 32'(stall_o), 32'd0);
      tick();
      chk("f_valid_pulse", 32'(inst_valid), 32'd0);

      // Simultaneous load + fetch: data first, fetch follows with no gap
      data_req = 1'b1; data_we = 1'b0; data_addr = 32'h100;
      inst_req = 1'b1; inst_addr = 32'h44;
      tick();
      chk("s_addr_data", bus_addr, 32'h100);
      chk("s_req_data", 32'(bus_req), 32'd1);
      data_req = 1'b0; inst_req = 1'b0; bus_addr_ok = 1'b1;
      tick();
      chk("s_dwait_req", 32'(bus_req), 32'd0);
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_2222;
      tick();
      bus_data_ok = 1'b0;
      chk("s_data_valid", 32'(data_valid), 32'd1);
      chk("s_data_rdata", data_rdata, 32'h1111_2222);
      chk("s_inst_not_yet", 32'(inst_valid), 32'd0);
      chk("s_addr_inst", bus_addr, 32'h44);
      chk("s_req_inst", 32'(bus_req), 32'd1);
      chk("s_stall", 32'(stall_o), 32'd1);
      bus_addr_ok = 1'b1;
      tick();
      chk("s_dvalid_pulse", 32'(data_valid), 32'd0);
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3333_4444;
      tick();
      bus_data_ok = 1'b0;
      chk("s_inst_valid", 32'(inst_valid), 32'd1);
      chk("s_inst_rdata", inst_rdata, 32'h3333_4444);
      chk("s_idle", 32'(stall_o), 32'd0);

      // Store
      data_req = 1'b1; data_we = 1'b1; data_wen = 4'b0011;
      data_wdata = 32'hDEAD_BEEF; data_addr = 32'h200;
      tick();
      chk("w_bus_wr", 32'(bus_wr), 32'd1);
      chk("w_wstrb", 32'(bus_wstrb), 32'h3);
      chk("w_addr", bus_addr, 32'h200);
      chk("w_wdata", bus_wdata, 32'hDEAD_BEEF);
      data_req = 1'b0; data_we = 1'b0; data_wen = '0; bus_addr_ok = 1'b1;
      tick();
      chk("w_wr_drop", 32'({bus_wr, bus_wstrb}), 32'd0);
      chk("w_addr_hold", bus_addr, 32'h200);
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
      tick();
      bus_data_ok = 1'b0;
      chk("w_data_valid", 32'(data_valid), 32'd1);
      chk("w_rdata_kept", data_rdata, 32'h1111_2222);
      chk("w_no_inst", 32'(inst_valid), 32'd0);

      // Backpressure on a fetch; changing inputs are ignored
      inst_req = 1'b1; inst_addr = 32'h80;
      tick();
      for (int i = 0; i < 5; i++) begin
         inst_addr = 32'h1000 + 32'(i); data_req = i[0]; data_addr = 32'h2000 + 32'(i);
         data_we = 1'b1; data_wen = 4'hF;
         chk("bp_req", 32'(bus_req), 32'd1);
         chk("bp_addr", bus_addr, 32'h80);
         chk("bp_stall", 32'(stall_o), 32'd1);
         chk("bp_wr", 32'(bus_wr), 32'd0);
         tick();
      end
      inst_req = 1'b0; data_req = 1'b0; data_we = 1'b0; data_wen = '0;
      bus_addr_ok = 1'b1;
      tick();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_0055;
      tick();
      bus_data_ok = 1'b0;
      chk("bp_inst_valid", 32'(inst_valid), 32'd1);
      chk("bp_inst_rdata", inst_rdata, 32'h55);
      chk("bp_no_data", 32'(data_valid), 32'd0);

      // Spurious data_ok in IDLE and D_ADDR
      bus_data_ok = 1'b1; bus_rdata = 32'hBAD0_BAD0;
      tick();
      chk("sp_idle_valid", 32'({inst_valid, data_valid}), 32'd0);
      chk("sp_idle_stall", 32'(stall_o), 32'd0);
      bus_data_ok = 1'b0;
      data_req = 1'b1; data_we = 1'b0; data_addr = 32'h300;
      tick();
      data_req = 1'b0; bus_data_ok = 1'b1;
      tick();
      bus_data_ok = 1'b0;
      chk("sp_daddr_req", 32'(bus_req), 32'd1);
      chk("sp_daddr_valid", 32'(data_valid), 32'd0);
      chk("sp_daddr_addr", bus_addr, 32'h300);
      bus_addr_ok = 1'b1;
      tick();
      bus_addr_ok = 1'b0;
      chk("sp_dwait", 32'({bus_req, stall_o}), 32'b01);

      // Reset in D_WAIT, then a late data_ok
      rst = 1'b1;
      #1;
      chk("r_stall", 32'(stall_o), 32'd0);
      chk("r_bus_req", 32'(bus_req), 32'd0);
      chk("r_bus_addr", bus_addr, 32'd0);
      chk("r_rdata", inst_rdata | data_rdata, 32'd0);
      tick();
      rst = 1'b0;
      bus_data_ok = 1'b1; bus_rdata = 32'h7777_7777;
      tick();
      bus_data_ok = 1'b0;
      chk("r_late_valid", 32'({inst_valid, data_valid}), 32'd0);
      chk("r_late_rdata", data_rdata, 32'd0);
      chk("r_late_stall", 32'(stall_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
